// File: rtl/alu_muldiv_pkg.sv
// Shared opcode encodings and FSM states for the EX-stage ALU with RV32M extension.
package alu_muldiv_pkg;

  localparam logic [5:0] ALU_ADD    = 6'd0;
  localparam logic [5:0] ALU_SUB    = 6'd1;
  localparam logic [5:0] ALU_SLL    = 6'd2;
  localparam logic [5:0] ALU_SLT    = 6'd3;
  localparam logic [5:0] ALU_SLTU   = 6'd4;
  localparam logic [5:0] ALU_XOR    = 6'd5;
  localparam logic [5:0] ALU_SRL    = 6'd6;
  localparam logic [5:0] ALU_SRA    = 6'd7;
  localparam logic [5:0] ALU_OR     = 6'd8;
  localparam logic [5:0] ALU_AND    = 6'd9;
  localparam logic [5:0] ALU_EQ     = 6'd16;
  localparam logic [5:0] ALU_NE     = 6'd17;
  localparam logic [5:0] ALU_LT     = 6'd18;
  localparam logic [5:0] ALU_GE     = 6'd19;
  localparam logic [5:0] ALU_LTU    = 6'd20;
  localparam logic [5:0] ALU_GEU    = 6'd21;

  // M-ops occupy 6'b100xxx: bit 2 selects divide, bit 1 selects remainder.
  localparam logic [5:0] ALU_MUL    = 6'd32;
  localparam logic [5:0] ALU_MULH   = 6'd33;
  localparam logic [5:0] ALU_MULHSU = 6'd34;
  localparam logic [5:0] ALU_MULHU  = 6'd35;
  localparam logic [5:0] ALU_DIV    = 6'd36;
  localparam logic [5:0] ALU_DIVU   = 6'd37;
  localparam logic [5:0] ALU_REM    = 6'd38;
  localparam logic [5:0] ALU_REMU   = 6'd39;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  function automatic logic is_mop(input logic [5:0] s);
    return s[5:3] == 3'b100;
  endfunction

endpackage

// File: rtl/alu_muldiv_base.sv
// Combinational base RV32I ALU / branch-compare slice with masked shift amounts.
module alu_base_comb
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [5:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic             CMP
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;
  logic           lt, ltu, eq;

  assign shamt = B[SHW-1:0];
  assign lt    = $signed(A) < $signed(B);
  assign ltu   = A < B;
  assign eq    = A == B;

  always_comb begin
    Q   = '0;
    CMP = 1'b0;
    case (S)
      ALU_ADD:  Q = A + B;
      ALU_SUB:  Q = A - B;
      ALU_SLL:  Q = A << shamt;
      ALU_SLT:  Q = {{(WIDTH-1){1'b0}}, lt};
      ALU_SLTU: Q = {{(WIDTH-1){1'b0}}, ltu};
      ALU_XOR:  Q = A ^ B;
      ALU_SRL:  Q = A >> shamt;
      ALU_SRA:  Q = WIDTH'($signed(A) >>> shamt);
      ALU_OR:   Q = A | B;
      ALU_AND:  Q = A & B;
      ALU_EQ:   CMP = eq;
      ALU_NE:   CMP = !eq;
      ALU_LT:   CMP = lt;
      ALU_GE:   CMP = !lt;
      ALU_LTU:  CMP = ltu;
      ALU_GEU:  CMP = !ltu;
      default: begin
        Q   = '0;
        CMP = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked EX-stage ALU: registered base ops plus iterative RV32M multiply/divide.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             CMP
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state, state_nxt;
  logic [5:0]           op;
  logic [WIDTH-1:0]     opb;
  logic [2*WIDTH-1:0]   acc;
  logic [SHW-1:0]       cnt;
  logic                 neg_q, neg_r;

  logic [WIDTH-1:0]     base_q;
  logic                 base_cmp;
  logic                 accept, mop, special;
  logic                 a_signed, b_signed, sa, sb;
  logic [WIDTH-1:0]     amag, bmag, spec_q;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     diff;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt, prod;
  logic [WIDTH-1:0]     quo, rem, fix_q;

  alu_base_comb #(.WIDTH(WIDTH)) u_base (
    .S   (S),
    .A   (A),
    .B   (B),
    .Q   (base_q),
    .CMP (base_cmp)
  );

  assign in_ready  = state == ST_IDLE;
  assign out_valid = state == ST_DONE;
  assign accept    = in_valid && in_ready;
  assign mop       = is_mop(S);

  // Operand decode at accept: magnitudes, result signs and the no-iteration cases.
  always_comb begin
    a_signed = S inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    b_signed = S inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    sa       = a_signed && A[WIDTH-1];
    sb       = b_signed && B[WIDTH-1];
    amag     = sa ? -A : A;
    bmag     = sb ? -B : B;
    special  = mop && S[2] &&
               ((B == '0) || ((S == ALU_DIV || S == ALU_REM) && A == MIN && B == '1));
    if (B == '0) spec_q = S[1] ? A : '1;
    else         spec_q = S[1] ? '0 : MIN;
  end

  // One shift-add step (acc = {partial, multiplier}) and one restoring-divide step
  // (acc = {remainder, dividend/quotient}); both share the same accumulator.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    mul_nxt = {mul_sum, acc[WIDTH-1:1]};
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = {1'b0, rem_sh} - {2'b00, opb};
    div_nxt = diff[WIDTH+1] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
    prod    = neg_q ? -acc : acc;
    quo     = acc[WIDTH-1:0];
    rem     = acc[2*WIDTH-1:WIDTH];
    if (op[2])            fix_q = op[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
    else if (op == ALU_MUL) fix_q = prod[WIDTH-1:0];
    else                  fix_q = prod[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (mop && !special) state_nxt = S[2] ? ST_DIV : ST_MUL;
          else                 state_nxt = ST_DONE;
        end
      end
      ST_MUL, ST_DIV: if (cnt == SHW'(WIDTH-1)) state_nxt = ST_FIX;
      ST_FIX:         state_nxt = ST_DONE;
      ST_DONE:        if (out_ready) state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) state <= ST_IDLE;
    else                state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      op    <= '0;
      opb   <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      Q     <= '0;
      CMP   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op    <= S;
            cnt   <= '0;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            if (mop && !special) begin
              opb <= S[2] ? bmag : amag;
              acc <= {{WIDTH{1'b0}}, (S[2] ? amag : bmag)};
            end else begin
              Q   <= mop ? spec_q : base_q;
              CMP <= mop ? 1'b0 : base_cmp;
            end
          end
        end
        ST_MUL: begin
          acc <= mul_nxt;
          cnt <= cnt + 1'b1;
        end
        ST_DIV: begin
          acc <= div_nxt;
          cnt <= cnt + 1'b1;
        end
        ST_FIX: begin
          Q   <= fix_q;
          CMP <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, CMP;
  logic [5:0]  S;
  logic [31:0] A, B, Q;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .CMP       (CMP)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op with out_ready high; measure accept-to-out_valid edges and check the result.
  task automatic run_op(input string tag, input logic [5:0] s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic ec, input int elat);
    int lat;
    @(negedge clk);
    S = s; A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; S = '0; A = '0; B = '0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " valid"}, 64'(out_valid), 64'd1);
    check({tag, " lat"}, 64'(lat), 64'(elat));
    check({tag, " Q"}, 64'(Q), 64'(eq));
    check({tag, " CMP"}, 64'(CMP), 64'(ec));
    @(posedge clk); #1;
  endtask

  task automatic abort_divu(input string tag, input logic use_reset);
    @(negedge clk);
    S = ALU_DIVU; A = 32'd1000; B = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check({tag, " busy in_ready"}, 64'(in_ready), 64'd0);
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    S = ALU_ADD; A = 32'd1; B = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " Q"}, 64'(Q), 64'd0);
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      check({tag, " no late valid"}, 64'(out_valid), 64'd0);
    end
    run_op({tag, " ADD"}, ALU_ADD, 32'd5, 32'd6, 32'd11, 1'b0, 1);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    S = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst Q", 64'(Q), 64'd0);
    check("rst CMP", 64'(CMP), 64'd0);

    run_op("SRA",    ALU_SRA,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1);
    run_op("SRL",    ALU_SRL,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000, 1'b0, 1);
    run_op("SLL",    ALU_SLL,  32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 1'b0, 1);
    run_op("SLTU",   ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
    run_op("SLT",    ALU_SLT,  32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
    run_op("SUB",    ALU_SUB,  32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1);
    run_op("BLT",    ALU_LT,   32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1);
    run_op("BLTU",   ALU_LTU,  32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1);
    run_op("BNE",    ALU_NE,   32'd4, 32'd4, 32'd0, 1'b0, 1);
    run_op("ADD",    ALU_ADD,  32'd5, 32'd6, 32'd11, 1'b0, 1);
    run_op("UNK",    6'd63,    32'd5, 32'd6, 32'd0, 1'b0, 1);

    run_op("MULH",   ALU_MULH,   32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("MUL",    ALU_MUL,    32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 1'b0, 34);
    run_op("MULHU",  ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);
    run_op("MULHSU", ALU_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("DIV",    ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34);
    run_op("REM",    ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("DIVU",   ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 34);
    run_op("REMU",   ALU_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 34);
    run_op("DIVU0",  ALU_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
    run_op("REMU0",  ALU_REMU, 32'd7, 32'd0, 32'd7, 1'b0, 1);
    run_op("DIVOVF", ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1);
    run_op("REMOVF", ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);

    // Result held while the consumer stalls; new requests are ignored.
    out_ready = 1'b0;
    @(negedge clk);
    S = ALU_XOR; A = 32'hF0F0_F0F0; B = 32'h0FF0_0FF0; in_valid = 1'b1;
    @(posedge clk); #1;
    check("hold first valid", 64'(out_valid), 64'd1);
    check("hold first Q", 64'(Q), 64'hFF00_FF00);
    @(negedge clk);
    S = ALU_ADD; A = 32'd1; B = 32'd2;
    repeat (5) begin
      @(posedge clk); #1;
      check("hold out_valid", 64'(out_valid), 64'd1);
      check("hold in_ready", 64'(in_ready), 64'd0);
      check("hold Q", 64'(Q), 64'hFF00_FF00);
    end
    @(negedge clk);
    out_ready = 1'b1; S = ALU_SUB; A = 32'd10; B = 32'd3;
    @(posedge clk); #1;
    check("release in_ready", 64'(in_ready), 64'd1);
    check("release out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b valid", 64'(out_valid), 64'd1);
    check("b2b Q", 64'(Q), 64'd7);
    @(posedge clk); #1;

    abort_divu("flush", 1'b0);
    abort_divu("reset", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
